// File: rtl/debounce_pkg.sv
// debounce_pkg: per-channel FSM state encoding and default timing constants
// shared by debounce_bank and debounce_channel.
package debounce_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } state_t;

    localparam int unsigned DEFAULT_CYCLES      = 10_000_000;
    localparam int unsigned DEFAULT_HOLD_CYCLES = 100_000_000;

    // Stable state that matches a given accepted level.
    function automatic state_t stable_state(input logic level);
        return level ? STABLE_HI : STABLE_LO;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one debounced input -- two-flop synchroniser, four-state
// stability FSM with a saturating-free bounded counter, registered edge pulses.
// Optional long-press detection is built only when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned CYCLES        = DEFAULT_CYCLES,
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter logic        RESET_VALUE   = 1'b0,
    parameter int unsigned HOLD_CYCLES   = DEFAULT_HOLD_CYCLES
) (
    input  logic clk,
    input  logic rstb,
    input  logic bouncy,
    output logic debounced,
    output logic rise,
    output logic fall,
    output logic long_press
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_WIDTH'(CYCLES);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    logic                     sync_q1, sync_q2;
    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic                     deb_q, deb_d;
    logic                     rise_q, rise_d;
    logic                     fall_q, fall_d;

    // Two-flop synchroniser for the raw asynchronous input.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_q1 <= RESET_VALUE;
            sync_q2 <= RESET_VALUE;
        end else begin
            sync_q1 <= bouncy;
            sync_q2 <= sync_q1;
        end
    end

    // FSM, stability counter, accepted level and edge pulse registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= stable_state(RESET_VALUE);
            cnt_q   <= '0;
            deb_q   <= RESET_VALUE;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next state: a mismatch must persist through CYCLES+1 consecutive samples.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (sync_q2) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HI: begin
                if (!sync_q2) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    deb_d   = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!sync_q2) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LO: begin
                if (sync_q2) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    deb_d   = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    assign debounced = deb_q;
    assign rise      = rise_q;
    assign fall      = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned          HOLD_WIDTH = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX  = HOLD_WIDTH'(HOLD_CYCLES);

    logic [HOLD_WIDTH-1:0] hold_q, hold_d;
    logic                  long_d;

    // Hold counter follows the next accepted level so the pulse lands on pressed cycle HOLD_CYCLES.
    always_comb begin
        hold_d = '0;
        long_d = 1'b0;
        if (deb_d != RESET_VALUE) begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_WIDTH'(1);
            long_d = (hold_d == HOLD_MAX) && (hold_q != HOLD_MAX);
        end
    end

    // Hold counter and long-press pulse registers.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            hold_q     <= '0;
            long_press <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            long_press <= long_d;
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: N_CH independent debounced inputs with rise/fall pulses.
// Long-press pulses are produced only when DEBOUNCE_LONG_PRESS_EN is defined;
// otherwise long_press is tied low.
module debounce_bank
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH          = 8,
    parameter int unsigned CYCLES        = DEFAULT_CYCLES,
    parameter int unsigned COUNTER_WIDTH = 32,
    parameter logic        RESET_VALUE   = 1'b0,
    parameter int unsigned HOLD_CYCLES   = DEFAULT_HOLD_CYCLES
) (
    input  logic            clk,
    input  logic            rstb,
    input  logic [N_CH-1:0] bouncy,
    output logic [N_CH-1:0] debounced,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long_press
);

    if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
        $error("debounce_bank: N_CH must be in 1..32");
    end
    if (CYCLES < 1) begin : g_bad_cycles
        $error("debounce_bank: CYCLES must be at least 1");
    end
    if (COUNTER_WIDTH < 1 ||
        (COUNTER_WIDTH < 32 && CYCLES > ((32'd1 << COUNTER_WIDTH) - 32'd1))) begin : g_bad_width
        $error("debounce_bank: CYCLES does not fit in COUNTER_WIDTH bits");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .CYCLES        (CYCLES),
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .RESET_VALUE   (RESET_VALUE),
            .HOLD_CYCLES   (HOLD_CYCLES)
        ) u_ch (
            .clk        (clk),
            .rstb       (rstb),
            .bouncy     (bouncy[i]),
            .debounced  (debounced[i]),
            .rise       (rise[i]),
            .fall       (fall[i]),
            .long_press (long_press[i])
        );
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: table-driven, hand-written and random checks of two
// debounce_bank instances (RESET_VALUE 0 and 1) against a window-based model.
module tb_debounce_bank;

    localparam int unsigned CYC      = 4;
    localparam int unsigned HOLD     = 10;
    localparam int unsigned HIST_TOP = CYC + 2;
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int LP_EXP = 1;
`else
    localparam int LP_EXP = 0;
`endif

    logic       clk = 1'b0;
    logic       rstb = 1'b0;
    logic [3:0] bouncy = 4'b0000;
    logic [3:0] bouncy1 = 4'b1111;
    logic [3:0] deb0, rise0, fall0, lp0;
    logic [3:0] deb1, rise1, fall1, lp1;

    always #5 clk = ~clk;

    debounce_bank #(
        .N_CH(4), .CYCLES(CYC), .COUNTER_WIDTH(3), .RESET_VALUE(1'b0), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rstb(rstb), .bouncy(bouncy),
        .debounced(deb0), .rise(rise0), .fall(fall0), .long_press(lp0)
    );

    debounce_bank #(
        .N_CH(4), .CYCLES(CYC), .COUNTER_WIDTH(3), .RESET_VALUE(1'b1), .HOLD_CYCLES(HOLD)
    ) dut1 (
        .clk(clk), .rstb(rstb), .bouncy(bouncy1),
        .debounced(deb1), .rise(rise1), .fall(fall1), .long_press(lp1)
    );

    int checks = 0;
    int errors = 0;

    // Model: a level is accepted once the last CYC+1 synchronised samples
    // (raw input delayed two edges) all differ from the accepted level.
    logic [3:0]  hist [2][HIST_TOP+1];
    logic [3:0]  m_deb [2];
    logic [3:0]  m_rise [2];
    logic [3:0]  m_fall [2];
    logic [3:0]  m_lp [2];
    int unsigned press_len [2][4];

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input int i, input logic [3:0] b, input logic rv);
        m_rise[i] = '0;
        m_fall[i] = '0;
        m_lp[i]   = '0;
        if (!rstb) begin
            for (int k = 0; k <= HIST_TOP; k++) hist[i][k] = {4{rv}};
            m_deb[i] = {4{rv}};
            for (int c = 0; c < 4; c++) press_len[i][c] = 0;
            return;
        end
        for (int k = HIST_TOP; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = b;
        for (int c = 0; c < 4; c++) begin
            logic all_diff;
            all_diff = 1'b1;
            for (int k = 2; k <= HIST_TOP; k++)
                if (hist[i][k][c] == m_deb[i][c]) all_diff = 1'b0;
            if (all_diff) begin
                m_deb[i][c] = ~m_deb[i][c];
                if (m_deb[i][c]) m_rise[i][c] = 1'b1;
                else             m_fall[i][c] = 1'b1;
            end
            if (m_deb[i][c] != rv) press_len[i][c]++;
            else                   press_len[i][c] = 0;
`ifdef DEBOUNCE_LONG_PRESS_EN
            if (press_len[i][c] == HOLD) m_lp[i][c] = 1'b1;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(0, bouncy, 1'b0);
        model_edge(1, bouncy1, 1'b1);
        #1;
        check4("deb0",  deb0,  m_deb[0]);
        check4("rise0", rise0, m_rise[0]);
        check4("fall0", fall0, m_fall[0]);
        check4("lp0",   lp0,   m_lp[0]);
        check4("deb1",  deb1,  m_deb[1]);
        check4("rise1", rise1, m_rise[1]);
        check4("fall1", fall1, m_fall[1]);
        check4("lp1",   lp1,   m_lp[1]);
    endtask

    typedef struct {
        logic [3:0]  in;
        int unsigned len;
        logic [3:0]  deb;
        logic [3:0]  rise;
        logic [3:0]  fall;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rs0, fs0, rs1, fs1;
        int first, nrise, others, npulse, r_e, lp_e, nlp, nlp1;

        // bouncy1 is driven with ~in, so the RESET_VALUE=1 instance mirrors it.
        tbl[0] = '{4'b0001, 10, 4'b0001, 4'b0001, 4'b0000};  // ch0 step
        tbl[1] = '{4'b0011,  3, 4'b0001, 4'b0000, 4'b0000};  // ch1 glitch, 3 cycles
        tbl[2] = '{4'b0001, 10, 4'b0001, 4'b0000, 4'b0000};
        tbl[3] = '{4'b1101, 10, 4'b1101, 4'b1100, 4'b0000};  // ch2+ch3 together
        tbl[4] = '{4'b1001, 10, 4'b1001, 4'b0000, 4'b0100};  // ch2 drops alone
        tbl[5] = '{4'b0000, 10, 4'b0000, 4'b0000, 4'b1001};

        repeat (3) tick();
        check4("reset_deb0", deb0, 4'b0000);
        check4("reset_deb1", deb1, 4'b1111);
        rstb = 1'b1;

        foreach (tbl[r]) begin
            bouncy  = tbl[r].in;
            bouncy1 = ~tbl[r].in;
            rs0 = '0; fs0 = '0; rs1 = '0; fs1 = '0;
            for (int e = 0; e < int'(tbl[r].len); e++) begin
                tick();
                rs0 |= rise0; fs0 |= fall0; rs1 |= rise1; fs1 |= fall1;
            end
            check4("tbl_deb0",  deb0, tbl[r].deb);
            check4("tbl_rise0", rs0,  tbl[r].rise);
            check4("tbl_fall0", fs0,  tbl[r].fall);
            check4("tbl_deb1",  deb1, ~tbl[r].deb);
            check4("tbl_rise1", rs1,  tbl[r].fall);
            check4("tbl_fall1", fs1,  tbl[r].rise);
        end

        // Clean step: accepted exactly CYC+2 edges after the first sampling edge.
        bouncy = 4'b0001; bouncy1 = 4'b1110;
        first = -1; nrise = 0; others = 0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (first < 0 && deb0[0]) first = e;
            if (rise0[0]) nrise++;
            if (deb0[3:1] != 3'b000 || rise0[3:1] != 3'b000) others++;
        end
        check_int("step_latency", first, CYC + 2);
        check_int("step_rise_width", nrise, 1);
        check_int("step_other_channels", others, 0);
        bouncy = 4'b0000; bouncy1 = 4'b1111;
        repeat (10) tick();

        // Reset in the middle of a pending change, input held at the new level.
        bouncy = 4'b0001; bouncy1 = 4'b1110;
        npulse = 0;
        repeat (3) begin
            tick();
            if ((rise0 | fall0 | rise1 | fall1) != 4'b0000) npulse++;
        end
        rstb = 1'b0;
        #1;
        check4("async_reset_deb0", deb0, 4'b0000);
        check4("async_reset_deb1", deb1, 4'b1111);
        repeat (2) begin
            tick();
            if ((rise0 | fall0 | rise1 | fall1) != 4'b0000) npulse++;
        end
        check_int("reset_no_pulse", npulse, 0);
        rstb = 1'b1;
        first = -1;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (first < 0 && deb0[0]) first = e;
        end
        check_int("reset_release_latency", first, CYC + 2);

        // Long press: hold ch0 well beyond HOLD cycles.
        bouncy = 4'b0000; bouncy1 = 4'b1111;
        repeat (10) tick();
        bouncy = 4'b0001; bouncy1 = 4'b1110;
        r_e = -100; lp_e = -1; nlp = 0; nlp1 = 0;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (rise0[0]) r_e = e;
            if (lp0[0]) begin nlp++; lp_e = e; end
            if (lp1[0]) nlp1++;
        end
        check_int("lp_count0", nlp, LP_EXP);
        check_int("lp_count1", nlp1, LP_EXP);
`ifdef DEBOUNCE_LONG_PRESS_EN
        check_int("lp_offset", lp_e - r_e, int'(HOLD) - 1);
`endif
        bouncy = 4'b0000; bouncy1 = 4'b1111;
        repeat (10) tick();

        // Random stimulus with occasional resets.
        for (int t = 0; t < 400; t++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(7) == 0) bouncy[c]  = ~bouncy[c];
                if ($urandom_range(7) == 0) bouncy1[c] = ~bouncy1[c];
            end
            rstb = ($urandom_range(149) == 0) ? 1'b0 : 1'b1;
            tick();
        end
        rstb = 1'b1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter N_CH, default 8: number of independent input channels, range 1 to 32.
REQ-002 Parameter CYCLES, default 10_000_000: stable cycles needed to accept a level change, at least 1.
REQ-003 Parameter COUNTER_WIDTH, default 32: width of the per-channel stability counter; CYCLES SHALL be at most 2^COUNTER_WIDTH-1, otherwise elaboration errors.
REQ-004 Parameter RESET_VALUE, default 1'b0: idle ("released") level applied to every channel.
REQ-005 Parameter HOLD_CYCLES, default 100_000_000: pressed duration for a long-press event; used only with DEBOUNCE_LONG_PRESS_EN.
REQ-006 clk  input  1: the single clock; all state SHALL be updated on its rising edge.
REQ-007 rstb  input  1: asynchronous, active-low reset.
REQ-008 bouncy  input  N_CH: raw asynchronous inputs, one bit per channel.
REQ-009 debounced  output  N_CH: accepted stable level per channel.
REQ-010 rise  output  N_CH: one-cycle pulse when debounced goes 0->1.
REQ-011 fall  output  N_CH: one-cycle pulse when debounced goes 1->0.
REQ-012 long_press  output  N_CH: one-cycle long-press pulse; the port SHALL exist in both build configurations.

Function
REQ-013 Each channel SHALL pass bouncy through a two-flop synchroniser before any other logic.
REQ-014 Each channel SHALL run a four-state FSM: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-015 When the synchronised level differs from debounced, the FSM SHALL move STABLE_x->WAIT_y and the counter SHALL increment every cycle.
REQ-016 If the synchronised level returns to debounced while in WAIT_y, the FSM SHALL return to STABLE_x, clear the counter, and leave the output unchanged.
REQ-017 When the counter reaches CYCLES while still mismatched, the channel SHALL enter STABLE_y, toggle debounced, and clear the counter.
REQ-018 A clean input step SHALL change debounced exactly CYCLES+2 rising edges after the first edge that samples the new level.
REQ-019 Any glitch shorter than CYCLES synchronised cycles SHALL produce no output change and no pulse.
REQ-020 rise and fall SHALL be registered and asserted in the same cycle debounced first shows its new value, for exactly one cycle.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each be debounced and pulsed in the same cycle.
REQ-022 The counter SHALL never exceed CYCLES and SHALL never wrap.

Reset
REQ-023 While rstb=0, synchroniser flops and debounced SHALL equal RESET_VALUE, states SHALL be the matching STABLE state, and counters, rise, fall and long_press SHALL be 0.
REQ-024 Reset asserted mid-count SHALL discard the pending change immediately, with no pulse.
REQ-025 On release, a bouncy level different from RESET_VALUE SHALL be debounced normally (CYCLES+2 edges), never accepted instantly.

Configuration
REQ-026 With DEBOUNCE_LONG_PRESS_EN defined, each channel SHALL hold a saturating hold counter that counts while debounced != RESET_VALUE and clears on release.
REQ-027 With DEBOUNCE_LONG_PRESS_EN defined, long_press SHALL pulse once when the hold count reaches HOLD_CYCLES, with no repeat until released and pressed again.
REQ-028 Without DEBOUNCE_LONG_PRESS_EN, long_press SHALL be constant 0 and no hold counters SHALL be synthesised.

Structure
REQ-029 The shared package debounce_pkg SHALL hold the FSM state encoding (2-bit localparams) and the default CYCLES and HOLD_CYCLES constants.
REQ-030 A sub-module debounce_channel SHALL implement one channel (synchroniser, FSM, counter, pulses, optional hold logic), instantiated N_CH times by a generate loop.

Verification (N_CH=4, CYCLES=4, HOLD_CYCLES=10, RESET_VALUE=0 unless stated)
REQ-031 Step test: ch0 0->1 held -> debounced[0]=1 and rise[0]=1 for one cycle, 6 edges after the first sampling edge; other channels stay 0.
REQ-032 Glitch test: ch1 high for 3 cycles, then low -> debounced[1], rise[1] and fall[1] stay 0 throughout.
REQ-033 Simultaneous test: ch2 and ch3 rise together -> both rise bits pulse in the same cycle; a later drop of ch2 only -> only fall[2] pulses.
REQ-034 Reset test: rstb low 2 cycles into a pending change, bouncy held at 1 -> no pulse; after release, debounced=1 exactly 6 edges later.
REQ-035 Long press (macro on): ch0 held 20 cycles -> one long_press[0] pulse at debounced-high cycle 10; macro off -> long_press stays 4'b0000.
REQ-036 RESET_VALUE=1: bouncy held at 1 through reset -> no pulses; press to 0 -> fall pulses, and with the macro on long_press counts while the level is 0.
